// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared opcodes, instruction layout and sequencer state encoding
package dsp_pkg;

    localparam int OP_W    = 6;
    localparam int FLD_DAW = 10;

    localparam logic [OP_W-1:0] OP_NOP = 6'h00;
    localparam logic [OP_W-1:0] OP_END = 6'h3F;

    localparam int OP_MSB = 35;
    localparam int OP_LSB = 30;
    localparam int W_MSB  = 29;
    localparam int W_LSB  = 20;
    localparam int A_MSB  = 19;
    localparam int A_LSB  = 10;
    localparam int B_MSB  = 9;
    localparam int B_LSB  = 0;

    typedef struct packed {
        logic [OP_W-1:0]    opcode;
        logic [FLD_DAW-1:0] addr_w;
        logic [FLD_DAW-1:0] addr_a;
        logic [FLD_DAW-1:0] addr_b;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

endpackage

// File: rtl/dsp_delay_line.sv
// rtl/dsp_delay_line.sv - fixed-depth register delay with an in-flight indicator
module dsp_delay_line #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_pending
);

    logic [W-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

    // Any nonzero entry short of the output stage is still travelling.
    always_comb begin
        o_pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            o_pending = o_pending | (|r_stage[i]);
        end
    end

endmodule

// File: rtl/dsp_sequencer.sv
// rtl/dsp_sequencer.sv - per-sample program sequencer; DSP_SEQ_OVERRUN_COUNT_EN adds overrunCount
module dsp_sequencer
    import dsp_pkg::*;
#(
    parameter int IAW      = 9,
    parameter int IWW      = 36,
    parameter int DAW      = 10,
    parameter int PROG_LEN = 512,
    parameter int WB_DELAY = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sampleTick,
    output logic [IAW-1:0]  addrI,
    input  logic [IWW-1:0]  dataI,
    output logic [DAW-1:0]  addrA,
    output logic [DAW-1:0]  addrB,
    output logic [OP_W-1:0] opcode,
    output logic            opValid,
    output logic [DAW-1:0]  addrW,
    output logic            writeEn,
    output logic            busy,
    output logic            done,
    output logic            overrun
`ifdef DSP_SEQ_OVERRUN_COUNT_EN
    ,
    output logic [15:0]     overrunCount
`endif
);

    localparam logic [IAW-1:0] PC_LAST = IAW'(PROG_LEN - 1);
    localparam int             DLW     = DAW + 2;

    seq_state_t      r_state;
    seq_state_t      w_state_nxt;
    logic [IAW-1:0]  r_pc;
    logic [IAW-1:0]  w_pc_nxt;
    logic            r_d_vld;
    logic            r_op_vld;
    logic [OP_W-1:0] r_opcode;
    logic [DAW-1:0]  r_addr_a;
    logic [DAW-1:0]  r_addr_b;
    logic            r_op_tok;
    logic            r_op_we;
    logic [DAW-1:0]  r_op_addr_w;
    logic            r_done;
    logic            r_overrun;

    instr_t          w_instr;
    logic            w_fetch;
    logic            w_end_dec;
    logic            w_live;
    logic            w_we;
    logic            w_start;
    logic            w_ovr;
    logic            w_busy;
    logic            w_done_nxt;
    logic            w_drained;
    logic [DLW-1:0]  w_dl_out;
    logic            w_dl_pending;
    logic            w_dl_tail_tok;

    always_comb begin
        w_instr.opcode = dataI[OP_MSB:OP_LSB];
        w_instr.addr_w = dataI[W_MSB:W_LSB];
        w_instr.addr_a = dataI[A_MSB:A_LSB];
        w_instr.addr_b = dataI[B_MSB:B_LSB];
    end

    assign w_fetch   = (r_state == RUN);
    assign w_end_dec = r_d_vld && (w_instr.opcode == OP_END);
    assign w_live    = r_d_vld && !w_end_dec;
    assign w_we      = w_live && (w_instr.opcode != OP_NOP);
    // A tick landing on the done cycle sees IDLE but must not restart the program.
    assign w_start   = sampleTick && (r_state == IDLE) && !r_done;
    assign w_ovr     = sampleTick && !w_start;

    // Each retiring slot (END included) carries a token so done waits for the last one.
    assign w_dl_tail_tok = w_dl_out[DLW-1];
    assign w_drained     = w_dl_tail_tok && !r_d_vld && !r_op_tok && !w_dl_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = RUN;
            RUN:     if (w_end_dec || (r_pc == PC_LAST)) w_state_nxt = DRAIN;
            DRAIN:   if (w_drained) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_busy     = (r_state != IDLE);
        w_done_nxt = (r_state == DRAIN) && w_drained;
        w_pc_nxt   = '0;
        if ((r_state == RUN) && (w_state_nxt == RUN)) begin
            w_pc_nxt = r_pc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= '0;
            r_d_vld     <= 1'b0;
            r_op_vld    <= 1'b0;
            r_opcode    <= '0;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_op_tok    <= 1'b0;
            r_op_we     <= 1'b0;
            r_op_addr_w <= '0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_d_vld     <= w_fetch && !w_end_dec;
            r_op_vld    <= w_live;
            r_opcode    <= w_live ? w_instr.opcode : '0;
            r_addr_a    <= w_live ? DAW'(w_instr.addr_a) : '0;
            r_addr_b    <= w_live ? DAW'(w_instr.addr_b) : '0;
            r_op_tok    <= r_d_vld;
            r_op_we     <= w_we;
            r_op_addr_w <= w_we ? DAW'(w_instr.addr_w) : '0;
            r_done      <= w_done_nxt;
            r_overrun   <= w_ovr;
        end
    end

    dsp_delay_line #(
        .W     (DLW),
        .DEPTH (WB_DELAY)
    ) u_wb_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_data    ({r_op_tok, r_op_we, r_op_addr_w}),
        .o_data    (w_dl_out),
        .o_pending (w_dl_pending)
    );

    assign addrI   = r_pc;
    assign addrA   = r_addr_a;
    assign addrB   = r_addr_b;
    assign opcode  = r_opcode;
    assign opValid = r_op_vld;
    assign writeEn = w_dl_out[DAW];
    assign addrW   = w_dl_out[DAW-1:0];
    assign busy    = w_busy;
    assign done    = r_done;
    assign overrun = r_overrun;

`ifdef DSP_SEQ_OVERRUN_COUNT_EN
    logic [15:0] r_ovr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr_cnt <= '0;
        end else if (r_overrun && (r_ovr_cnt != 16'hFFFF)) begin
            r_ovr_cnt <= r_ovr_cnt + 16'd1;
        end
    end

    assign overrunCount = r_ovr_cnt;
`endif

endmodule
